dac_tx_sched: RTL and testbench

DAC_TX_SCHED -- requirements
Module: dac_tx_sched

---
 rtl/dac_tx_sched.sv | 161 ++++++++++++++++
 tb/tb_dac_tx_sched.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/dac_tx_sched.sv
// dac_tx_sched -- trigger-driven DAC transmit scheduler.
//
// Once armed (on a rising edge of arm), the block waits for a trigger from the
// capture side. It then emits rep_qty_min1+1 dac_tx pulses. Each pulse is
// TX_HOLD cycles wide. The first rise comes dly cycles after the trigger
// cycle + 1, and later rises follow at a fixed rise-to-rise period.
//
// Ports
//   dac_clk, dac_resetn : clock, async active-low reset
//   arm                 : control level; its 0->1 edge arms the scheduler
//   abort               : synchronous return to IDLE (highest priority)
//   trig                : single-cycle trigger pulse
//   dly                 : trigger -> first rise delay, in cycles
//   pd_min1             : rise-to-rise period minus 1
//   rep_qty_min1        : number of transmissions minus 1
//   dac_tx              : transmit strobe to the DAC FIFO
//   busy                : high whenever not IDLE
//   done                : one-cycle pulse after the last transmission
//   rep_cnt             : transmissions issued in the current run
//   trig_miss           : saturating count of triggers seen outside ARMED
//   state               : IDLE=0 ARMED=1 DELAY=2 TX=3 GAP=4
module dac_tx_sched #(
    parameter int DLY_W   = 16,
    parameter int PD_W    = 24,
    parameter int REP_W   = 16,
    parameter int TX_HOLD = 4
) (
    input  logic             dac_clk,
    input  logic             dac_resetn,
    input  logic             arm,
    input  logic             abort,
    input  logic             trig,
    input  logic [DLY_W-1:0] dly,
    input  logic [PD_W-1:0]  pd_min1,
    input  logic [REP_W-1:0] rep_qty_min1,
    output logic             dac_tx,
    output logic             busy,
    output logic             done,
    output logic [REP_W-1:0] rep_cnt,
    output logic [7:0]       trig_miss,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARMED = 3'd1,
        S_DELAY = 3'd2,
        S_TX    = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    localparam int               HOLD_W  = $clog2(TX_HOLD + 1);
    localparam logic [PD_W-1:0]  HOLD_PD = PD_W'(TX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LD = HOLD_W'(TX_HOLD - 1);

    state_t             r_state, w_next;
    logic               r_arm_d;
    logic [DLY_W-1:0]   r_dcnt;
    logic [PD_W-1:0]    r_pd, r_pcnt;
    logic [REP_W-1:0]   r_rem, r_rep_cnt;
    logic [HOLD_W-1:0]  r_hold;
    logic [7:0]         r_miss;
    logic               r_tx, r_busy, r_done;

    logic               w_done, w_accept, w_tx_start;
    logic [PD_W-1:0]    w_pd_clamp, w_pd_use;

    // Period minus 1, floored at TX_HOLD so dac_tx always drops for at least
    // one cycle between pulses.
    assign w_pd_clamp = (pd_min1 < HOLD_PD) ? HOLD_PD : pd_min1;
    // On a dly=0 trigger the period register is not loaded yet, so take the
    // clamped input directly.
    assign w_pd_use   = (r_state == S_ARMED) ? w_pd_clamp : r_pd;

    always_comb begin
        w_next = r_state;
        w_done = 1'b0;
        case (r_state)
            S_IDLE:  if (arm && !r_arm_d) w_next = S_ARMED;
            S_ARMED: begin
                // trig beats a simultaneous arm drop
                if (trig)      w_next = (dly == '0) ? S_TX : S_DELAY;
                else if (!arm) w_next = S_IDLE;
            end
            S_DELAY: if (r_dcnt == '0) w_next = S_TX;
            S_TX: begin
                if (r_hold == '0) begin
                    if (r_rem == '0) begin
                        w_next = S_IDLE;
                        w_done = 1'b1;
                    end else begin
                        w_next = S_GAP;
                    end
                end
            end
            S_GAP:   if (r_pcnt == '0) w_next = S_TX;
            default: w_next = S_IDLE;
        endcase
        if (abort) begin
            w_next = S_IDLE;
            w_done = 1'b0;
        end
    end

    assign w_accept   = (r_state == S_ARMED) && trig && !abort;
    assign w_tx_start = (w_next == S_TX) && (r_state != S_TX);

    always_ff @(posedge dac_clk or negedge dac_resetn) begin
        if (!dac_resetn) begin
            r_state   <= S_IDLE;
            r_arm_d   <= 1'b0;
            r_tx      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_rep_cnt <= '0;
            r_dcnt    <= '0;
            r_pd      <= '0;
            r_pcnt    <= '0;
            r_rem     <= '0;
            r_hold    <= '0;
            r_miss    <= '0;
        end else begin
            r_state <= w_next;
            r_arm_d <= arm;
            r_tx    <= (w_next == S_TX);
            r_busy  <= (w_next != S_IDLE);
            r_done  <= w_done;

            if (r_state == S_IDLE && w_next == S_ARMED) r_rep_cnt <= '0;
            else if (w_tx_start)                         r_rep_cnt <= r_rep_cnt + 1'b1;

            // Delay counter holds dly-1 so DELAY lasts exactly dly cycles.
            if (w_accept)                                r_dcnt <= dly - 1'b1;
            else if (r_state == S_DELAY && r_dcnt != '0) r_dcnt <= r_dcnt - 1'b1;

            if (w_accept) r_pd <= w_pd_clamp;

            if (w_accept)                           r_rem <= rep_qty_min1;
            else if (w_tx_start && r_state == S_GAP) r_rem <= r_rem - 1'b1;

            if (w_tx_start)                           r_hold <= HOLD_LD;
            else if (r_state == S_TX && r_hold != '0) r_hold <= r_hold - 1'b1;

            // Period counter runs across TX and GAP, reloaded on every rise.
            if (w_tx_start)
                r_pcnt <= w_pd_use;
            else if ((r_state == S_TX || r_state == S_GAP) && r_pcnt != '0)
                r_pcnt <= r_pcnt - 1'b1;

            if (trig && r_state != S_ARMED && r_miss != 8'hFF) r_miss <= r_miss + 1'b1;
        end
    end

    assign dac_tx    = r_tx;
    assign busy      = r_busy;
    assign done      = r_done;
    assign rep_cnt   = r_rep_cnt;
    assign trig_miss = r_miss;
    assign state     = r_state;

endmodule

// File: tb/tb_dac_tx_sched.sv
// Randomized bench for dac_tx_sched. Expected waveforms come from closed-form
// rise times: rise_k = T+1+dly+k*P, P = max(pd_min1+1, TX_HOLD+1).
module tb_dac_tx_sched;

    localparam int DLY_W = 16;
    localparam int PD_W  = 24;
    localparam int REP_W = 16;
    localparam int H     = 4;

    logic             dac_clk, dac_resetn, arm, abort, trig;
    logic [DLY_W-1:0] dly;
    logic [PD_W-1:0]  pd_min1;
    logic [REP_W-1:0] rep_qty_min1;
    logic             dac_tx, busy, done;
    logic [REP_W-1:0] rep_cnt;
    logic [7:0]       trig_miss;
    logic [2:0]       state;

    int nvec = 0;
    int nerr = 0;
    int exp_miss = 0;

    dac_tx_sched #(.DLY_W(DLY_W), .PD_W(PD_W), .REP_W(REP_W), .TX_HOLD(H)) dut (
        .dac_clk(dac_clk), .dac_resetn(dac_resetn), .arm(arm), .abort(abort),
        .trig(trig), .dly(dly), .pd_min1(pd_min1), .rep_qty_min1(rep_qty_min1),
        .dac_tx(dac_tx), .busy(busy), .done(done), .rep_cnt(rep_cnt),
        .trig_miss(trig_miss), .state(state)
    );

    initial begin
        dac_clk = 1'b0;
        forever #5 dac_clk = ~dac_clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge dac_clk);
        #1;
    endtask

    function automatic int sat_inc(input int v);
        return (v < 255) ? v + 1 : 255;
    endfunction

    // One full run. abort_k / rst_k (>0) fire abort / reset during cycle T+k.
    task automatic run(input int d, input int p, input int r, input int abort_k, input int rst_k);
        int peff, n, last, o, idx, ph, e_st, e_rc;
        logic e_tx, e_done;
        arm = 1'b0; tick;
        arm = 1'b1; tick;
        chk("armed_state", 32'(state), 1);
        chk("armed_repcnt", 32'(rep_cnt), 0);
        repeat ($urandom_range(0, 3)) tick;
        chk("armed_wait", 32'(state), 1);
        dly = DLY_W'(d); pd_min1 = PD_W'(p); rep_qty_min1 = REP_W'(r);
        trig = 1'b1; tick; trig = 1'b0;
        // Inputs are scrambled after T; the run must ignore them.
        dly = DLY_W'($urandom_range(0, 40));
        pd_min1 = PD_W'($urandom_range(0, 40));
        rep_qty_min1 = REP_W'($urandom_range(0, 9));
        peff = (p + 1 > H) ? p + 1 : H + 1;
        n    = r + 1;
        last = 1 + d + (n - 1) * peff + H;
        for (int k = 1; k <= last; k++) begin
            o = k - 1 - d;
            e_tx = 1'b0; e_done = 1'b0;
            if (o < 0) begin
                e_st = 2; e_rc = 0;
            end else begin
                idx = o / peff; ph = o % peff;
                if (idx < n && ph < H) begin
                    e_st = 3; e_tx = 1'b1; e_rc = idx + 1;
                end else if (o == (n - 1) * peff + H) begin
                    e_st = 0; e_done = 1'b1; e_rc = n;
                end else begin
                    e_st = 4; e_rc = idx + 1;
                end
            end
            chk("state", 32'(state), 32'(e_st));
            chk("dac_tx", 32'(dac_tx), 32'(e_tx));
            chk("done", 32'(done), 32'(e_done));
            chk("busy", 32'(busy), 32'(e_st != 0));
            chk("rep_cnt", 32'(rep_cnt), 32'(e_rc));
            if (k == abort_k) begin
                abort = 1'b1; tick; abort = 1'b0;
                chk("abort_state", 32'(state), 0);
                chk("abort_tx", 32'(dac_tx), 0);
                chk("abort_done", 32'(done), 0);
                chk("abort_repcnt", 32'(rep_cnt), 32'(e_rc));
                repeat (6) begin
                    tick;
                    chk("abort_nodone", 32'(done), 0);
                    chk("abort_idle", 32'(state), 0);
                end
                chk("trig_miss", 32'(trig_miss), 32'(exp_miss));
                return;
            end
            if (k == rst_k) begin
                dac_resetn = 1'b0; #1;
                exp_miss = 0;
                chk("rst_tx", 32'(dac_tx), 0);
                chk("rst_state", 32'(state), 0);
                chk("rst_busy", 32'(busy), 0);
                chk("rst_done", 32'(done), 0);
                chk("rst_repcnt", 32'(rep_cnt), 0);
                chk("rst_miss", 32'(trig_miss), 0);
                tick;
                chk("rst_hold", 32'(state), 0);
                #2 dac_resetn = 1'b1;
                tick;
                chk("rst_rearm", 32'(state), 1);
                return;
            end
            if (k < last) begin
                if ($urandom_range(0, 7) == 0) begin
                    trig = 1'b1;
                    exp_miss = sat_inc(exp_miss);
                end
                tick;
                trig = 1'b0;
            end
        end
        // arm still high: must not re-arm
        tick;
        chk("post_idle", 32'(state), 0);
        chk("post_done", 32'(done), 0);
        chk("post_repcnt", 32'(rep_cnt), 32'(n));
        chk("trig_miss", 32'(trig_miss), 32'(exp_miss));
    endtask

    initial begin
        dac_resetn = 1'b0; arm = 1'b0; abort = 1'b0; trig = 1'b0;
        dly = '0; pd_min1 = '0; rep_qty_min1 = '0;
        tick; tick;
        chk("reset_state", 32'(state), 0);
        chk("reset_tx", 32'(dac_tx), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_repcnt", 32'(rep_cnt), 0);
        chk("reset_miss", 32'(trig_miss), 0);
        #2 dac_resetn = 1'b1;
        tick;
        chk("idle_after_rst", 32'(state), 0);

        // three triggers while IDLE
        repeat (3) begin
            trig = 1'b1; tick; trig = 1'b0; tick;
            exp_miss = sat_inc(exp_miss);
        end
        chk("idle_miss", 32'(trig_miss), 32'(exp_miss));

        // arm dropped in ARMED -> IDLE, no done
        arm = 1'b1; tick; arm = 1'b0; tick;
        chk("disarm_state", 32'(state), 0);
        chk("disarm_done", 32'(done), 0);

        // trig together with arm falling: trig wins
        arm = 1'b1; tick;
        dly = DLY_W'(0); pd_min1 = PD_W'(0); rep_qty_min1 = REP_W'(0);
        arm = 1'b0; trig = 1'b1; tick; trig = 1'b0;
        chk("trig_wins", 32'(dac_tx), 1);
        repeat (H) tick;
        chk("trig_wins_done", 32'(done), 1);
        chk("trig_wins_cnt", 32'(rep_cnt), 1);

        run(3, 9, 2, 0, 0);       // basic run
        run(0, 1, 1, 0, 0);       // period clamp
        run(2, 9, 4, 14, 0);      // abort in second TX
        run(10, 5, 1, 0, 3);      // reset mid-DELAY, arm held high
        run(5, 6, 2, 0, 0);       // post-reset run with inputs changed after T
        for (int i = 0; i < 20; i++)
            run($urandom_range(0, 6), $urandom_range(0, 12), $urandom_range(0, 4), 0, 0);

        arm = 1'b0; tick;
        repeat (300) begin
            trig = 1'b1; tick;
            exp_miss = sat_inc(exp_miss);
        end
        trig = 1'b0; tick;
        chk("miss_sat", 32'(trig_miss), 32'(exp_miss));
        chk("miss_255", 32'(trig_miss), 255);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
